// File: rtl/muldiv_pkg.sv
// Shared constants for the EX-stage multiply/divide unit.
// Holds the operation codes decoded by ID, the FSM state encodings,
// the last iteration index and a small absolute-value helper.
package muldiv_pkg;

   localparam logic [2:0] OP_NONE   = 3'd0;
   localparam logic [2:0] OP_MULT   = 3'd1;
   localparam logic [2:0] OP_MULTU  = 3'd2;
   localparam logic [2:0] OP_DIV    = 3'd3;
   localparam logic [2:0] OP_DIVU   = 3'd4;
   localparam logic [2:0] OP_MTHI   = 3'd5;
   localparam logic [2:0] OP_MTLO   = 3'd6;
   localparam logic [2:0] OP_MFHILO = 3'd7;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   localparam logic [4:0] ITER_LAST = 5'd31;

   // 0x80000000 maps to itself, which is the correct unsigned magnitude.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Bundle between the ID/EX register / EX result mux and the mul/div unit.
//   i_valid, i_flush, i_op, i_operand_a, i_operand_b : request side
//   o_busy, o_stall, o_done, o_hi, o_lo              : status and HI/LO
// master: pipeline side, slave: the unit.
interface ex_muldiv_unit_if;
   logic        i_valid;
   logic        i_flush;
   logic [2:0]  i_op;
   logic [31:0] i_operand_a;
   logic [31:0] i_operand_b;
   logic        o_busy;
   logic        o_stall;
   logic        o_done;
   logic [31:0] o_hi;
   logic [31:0] o_lo;

   modport master (
      output i_valid, i_flush, i_op, i_operand_a, i_operand_b,
      input  o_busy, o_stall, o_done, o_hi, o_lo
   );

   modport slave (
      input  i_valid, i_flush, i_op, i_operand_a, i_operand_b,
      output o_busy, o_stall, o_done, o_hi, o_lo
   );
endinterface

// File: rtl/muldiv_core.sv
// Iterative datapath: 64-bit accumulator plus latched multiplicand/divisor.
//   load_i   : capture unsigned magnitudes a_i/b_i and the mul/div select
//   step_i   : one shift-add (mul) or restoring-divide (div) iteration
//   acc_o    : mul -> {product}, div -> {remainder, quotient}
module muldiv_core
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic        step_i,
   input  logic        is_div_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [63:0] acc_o
);

   logic [63:0] acc_q, acc_d;
   logic [31:0] opnd_q, opnd_d;
   logic        is_div_q, is_div_d;
   logic [32:0] mul_sum;
   logic [32:0] rem_sh;
   logic [33:0] diff;
   logic        unused_diff_bit;

   assign unused_diff_bit = diff[32];

   always_comb begin
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
      // Partial remainder after the left shift needs 33 bits.
      rem_sh   = acc_q[63:31];
      diff     = {1'b0, rem_sh} - {2'b00, opnd_q};
      if (load_i) begin
         is_div_d = is_div_i;
         if (is_div_i) begin
            acc_d  = {32'd0, a_i};
            opnd_d = b_i;
         end else begin
            acc_d  = {32'd0, b_i};
            opnd_d = a_i;
         end
      end else if (step_i) begin
         if (is_div_q) begin
            if (!diff[33]) acc_d = {diff[31:0], acc_q[30:0], 1'b1};
            else           acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
         end else begin
            acc_d = {mul_sum, acc_q[31:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q    <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit with architectural HI/LO.
//   clk, reset : clock, synchronous active-high reset
//   bus        : request (valid/flush/op/operands) and status (busy/stall/done/HI/LO)
//
// state | meaning
// IDLE  | accepting ops; MTHI/MTLO write here
// CALC  | 32 iterations in muldiv_core
// FIX   | apply signs, write HI/LO, pulse done next cycle
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input logic             clk,
   input logic             reset,
   ex_muldiv_unit_if.slave bus
);

   logic [1:0]            state_q, state_d;
   logic [4:0]            count_q, count_d;
   logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic                  done_q, done_d;
   logic                  neg_res_q, neg_res_d;
   logic                  neg_rem_q, neg_rem_d;
   logic                  is_div_q, is_div_d;
   logic                  dz_q, dz_d;
   logic [31:0]           dividend_q, dividend_d;

   logic        busy, accept, op_arith, op_signed, op_div;
   logic [63:0] acc, prod_fix;
   logic [31:0] quot_fix, rem_fix;

   assign busy      = (state_q != ST_IDLE);
   assign accept    = bus.i_valid & ~bus.i_flush & ~busy & (bus.i_op != OP_NONE);
   assign op_arith  = (bus.i_op == OP_MULT) | (bus.i_op == OP_MULTU) |
                      (bus.i_op == OP_DIV)  | (bus.i_op == OP_DIVU);
   assign op_signed = (bus.i_op == OP_MULT) | (bus.i_op == OP_DIV);
   assign op_div    = (bus.i_op == OP_DIV)  | (bus.i_op == OP_DIVU);

   muldiv_core u_core (
      .clk      (clk),
      .reset    (reset),
      .load_i   (accept & op_arith),
      .step_i   (state_q == ST_CALC),
      .is_div_i (op_div),
      .a_i      (op_signed ? abs32(bus.i_operand_a) : bus.i_operand_a),
      .b_i      (op_signed ? abs32(bus.i_operand_b) : bus.i_operand_b),
      .acc_o    (acc)
   );

   assign prod_fix = neg_res_q ? (64'd0 - acc) : acc;
   assign quot_fix = neg_res_q ? (32'd0 - acc[31:0]) : acc[31:0];
   assign rem_fix  = neg_rem_q ? (32'd0 - acc[63:32]) : acc[63:32];

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      is_div_d   = is_div_q;
      dz_d       = dz_q;
      dividend_d = dividend_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (op_arith) begin
                  state_d    = ST_CALC;
                  count_d    = '0;
                  neg_res_d  = op_signed & (bus.i_operand_a[31] ^ bus.i_operand_b[31]);
                  neg_rem_d  = op_signed & op_div & bus.i_operand_a[31];
                  is_div_d   = op_div;
                  dz_d       = (bus.i_operand_b == 32'd0);
                  dividend_d = bus.i_operand_a;
               end else if (bus.i_op == OP_MTHI) begin
                  hi_d = bus.i_operand_a;
               end else if (bus.i_op == OP_MTLO) begin
                  lo_d = bus.i_operand_a;
               end
            end
         end
         ST_CALC: begin
            count_d = count_q + 5'd1;
            if (count_q == ITER_LAST) state_d = ST_FIX;
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            count_d = '0;
            done_d  = 1'b1;
            if (!is_div_q) begin
               hi_d = prod_fix[63:32];
               lo_d = prod_fix[31:0];
            end else if (dz_q) begin
               // Divide by zero leaves the original dividend in HI.
               hi_d = dividend_q;
               lo_d = 32'hFFFF_FFFF;
            end else begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         is_div_q   <= 1'b0;
         dz_q       <= 1'b0;
         dividend_q <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         is_div_q   <= is_div_d;
         dz_q       <= dz_d;
         dividend_q <= dividend_d;
      end
   end

   assign bus.o_busy  = busy;
   assign bus.o_stall = bus.i_valid & ~bus.i_flush & busy & (bus.i_op != OP_NONE);
   assign bus.o_done  = done_q;
   assign bus.o_hi    = hi_q;
   assign bus.o_lo    = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases, timing,
// stall behaviour, reset abort, back-to-back and randomized ops against
// an arithmetic reference model of HI/LO.
module tb_ex_muldiv_unit;
   import muldiv_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ex_muldiv_unit_if bus_if ();

   ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] m_hi, m_lo;

   function automatic void model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sp;
      logic [63:0] up;
      case (op)
         OP_MULT: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            up = sp; m_hi = up[63:32]; m_lo = up[31:0];
         end
         OP_MULTU: begin
            up = {32'd0, a} * {32'd0, b};
            m_hi = up[63:32]; m_lo = up[31:0];
         end
         OP_DIV: begin
            if (b == 0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
            else begin
               sp = longint'($signed(a)) / longint'($signed(b)); up = sp; m_lo = up[31:0];
               sp = longint'($signed(a)) % longint'($signed(b)); up = sp; m_hi = up[31:0];
            end
         end
         OP_DIVU: begin
            if (b == 0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
            else begin m_lo = a / b; m_hi = a % b; end
         end
         OP_MTHI: m_hi = a;
         OP_MTLO: m_lo = a;
         default: ;
      endcase
   endfunction

   task automatic idle_inputs();
      bus_if.i_valid     = 1'b0;
      bus_if.i_flush     = 1'b0;
      bus_if.i_op        = OP_NONE;
      bus_if.i_operand_a = '0;
      bus_if.i_operand_b = '0;
   endtask

   // Issue one mul/div op; returns the cycle index of o_done (-1 on timeout)
   // counted from the accept edge, and the number of busy cycles seen.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
      bus_if.i_valid = 1'b1; bus_if.i_op = op;
      bus_if.i_operand_a = a; bus_if.i_operand_b = b;
      @(posedge clk); #1;
      idle_inputs();
      lat = -1; busy_cnt = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus_if.o_busy) busy_cnt++;
         if (bus_if.o_done) begin lat = k; break; end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      checks++; if (bus_if.o_hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", bus_if.o_hi); end
      checks++; if (bus_if.o_lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", bus_if.o_lo); end
      checks++; if (bus_if.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus_if.o_busy); end
      checks++; if (bus_if.o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus_if.o_done); end
      checks++; if (bus_if.o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus_if.o_stall); end
      @(posedge clk); #1;
   endtask

   task automatic test_mult_timing();
      int lat, bc;
      do_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, bc);
      model_apply(OP_MULT, 32'hFFFF_FFFD, 32'd5);
      checks++; if (lat != 34) begin errors++; $display("FAIL mult_latency: got %0d expected 34", lat); end
      checks++; if (bc != 33) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 33", bc); end
      checks++; if (bus_if.o_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", bus_if.o_hi); end
      checks++; if (bus_if.o_lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo: got %h expected fffffff1", bus_if.o_lo); end
   endtask

   task automatic test_directed();
      logic [2:0]  ops [6] = '{OP_MULTU, OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIV};
      logic [31:0] va  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'hFFFF_FF9C, 32'd7};
      logic [31:0] vb  [6] = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE};
      logic [31:0] ehi [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd100, 32'd0, 32'hFFFF_FF9C, 32'd1};
      logic [31:0] elo [6] = '{32'h0000_0001, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      int lat, bc;
      for (int i = 0; i < 6; i++) begin
         do_op(ops[i], va[i], vb[i], lat, bc);
         model_apply(ops[i], va[i], vb[i]);
         checks++; if (lat != 34) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected 34", i, lat); end
         checks++; if (bus_if.o_hi !== ehi[i]) begin errors++; $display("FAIL directed_hi[%0d]: got %h expected %h", i, bus_if.o_hi, ehi[i]); end
         checks++; if (bus_if.o_lo !== elo[i]) begin errors++; $display("FAIL directed_lo[%0d]: got %h expected %h", i, bus_if.o_lo, elo[i]); end
      end
   endtask

   task automatic test_stall_mfhilo();
      bit seen_done = 0;
      bus_if.i_valid = 1'b1; bus_if.i_op = OP_DIVU;
      bus_if.i_operand_a = 32'd100; bus_if.i_operand_b = 32'd7;
      @(posedge clk); #1;
      // A non-muldiv instruction never stalls, even while busy.
      bus_if.i_op = OP_NONE;
      @(negedge clk);
      checks++; if (bus_if.o_stall !== 1'b0) begin errors++; $display("FAIL stall_nonmuldiv: got %b expected 0", bus_if.o_stall); end
      bus_if.i_op = OP_MFHILO;
      for (int k = 2; k <= 40; k++) begin
         @(negedge clk);
         if (bus_if.o_done) begin
            seen_done = 1;
            checks++; if (k != 34) begin errors++; $display("FAIL stall_done_cycle: got %0d expected 34", k); end
            checks++; if (bus_if.o_stall !== 1'b0) begin errors++; $display("FAIL stall_in_done: got %b expected 0", bus_if.o_stall); end
            break;
         end
         checks++; if (bus_if.o_stall !== 1'b1) begin errors++; $display("FAIL stall_busy[%0d]: got %b expected 1", k, bus_if.o_stall); end
      end
      checks++; if (!seen_done) begin errors++; $display("FAIL stall_timeout: got no done expected done"); end
      @(posedge clk); #1;
      idle_inputs();
      model_apply(OP_DIVU, 32'd100, 32'd7);
      checks++; if (bus_if.o_hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected 2", bus_if.o_hi); end
      checks++; if (bus_if.o_lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected e", bus_if.o_lo); end
   endtask

   task automatic test_mt();
      bit seen_done = 0;
      bus_if.i_valid = 1'b1; bus_if.i_op = OP_MTHI; bus_if.i_operand_a = 32'h1234_5678;
      @(negedge clk);
      checks++; if (bus_if.o_stall !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b expected 0", bus_if.o_stall); end
      @(posedge clk); #1;
      idle_inputs();
      model_apply(OP_MTHI, 32'h1234_5678, 32'd0);
      @(negedge clk);
      checks++; if (bus_if.o_hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_value: got %h expected 12345678", bus_if.o_hi); end
      @(posedge clk); #1;
      bus_if.i_valid = 1'b1; bus_if.i_op = OP_MULTU;
      bus_if.i_operand_a = 32'd3; bus_if.i_operand_b = 32'd4;
      @(posedge clk); #1;
      bus_if.i_op = OP_MTLO; bus_if.i_operand_a = 32'hCAFE_BABE; bus_if.i_operand_b = 32'd0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus_if.o_done) begin
            seen_done = 1;
            checks++; if (bus_if.o_lo !== 32'd12) begin errors++; $display("FAIL mtlo_inflight_lo: got %h expected c", bus_if.o_lo); end
            checks++; if (bus_if.o_stall !== 1'b0) begin errors++; $display("FAIL mtlo_stall_done: got %b expected 0", bus_if.o_stall); end
            break;
         end
         if (k == 5) begin
            checks++; if (bus_if.o_stall !== 1'b1) begin errors++; $display("FAIL mtlo_stall_busy: got %b expected 1", bus_if.o_stall); end
         end
      end
      checks++; if (!seen_done) begin errors++; $display("FAIL mtlo_timeout: got no done expected done"); end
      @(posedge clk); #1;
      idle_inputs();
      model_apply(OP_MULTU, 32'd3, 32'd4);
      model_apply(OP_MTLO, 32'hCAFE_BABE, 32'd0);
      @(negedge clk);
      checks++; if (bus_if.o_lo !== m_lo) begin errors++; $display("FAIL mtlo_final_lo: got %h expected %h", bus_if.o_lo, m_lo); end
      checks++; if (bus_if.o_hi !== m_hi) begin errors++; $display("FAIL mtlo_final_hi: got %h expected %h", bus_if.o_hi, m_hi); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit done_seen = 0;
      bus_if.i_valid = 1'b1; bus_if.i_op = OP_MULT;
      bus_if.i_operand_a = 32'h0001_0003; bus_if.i_operand_b = 32'h0000_0101;
      @(posedge clk); #1;
      idle_inputs();
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      checks++; if (bus_if.o_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", bus_if.o_busy); end
      checks++; if (bus_if.o_hi !== 32'd0 || bus_if.o_lo !== 32'd0) begin errors++; $display("FAIL midreset_hilo: got %h_%h expected 0_0", bus_if.o_hi, bus_if.o_lo); end
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus_if.o_done || bus_if.o_busy) done_seen = 1;
      end
      checks++; if (done_seen) begin errors++; $display("FAIL midreset_no_done: got activity expected none"); end
      @(posedge clk); #1;
   endtask

   task automatic test_flush();
      bus_if.i_valid = 1'b1; bus_if.i_flush = 1'b1; bus_if.i_op = OP_MULT;
      bus_if.i_operand_a = 32'd9; bus_if.i_operand_b = 32'd9;
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (bus_if.o_busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", bus_if.o_busy); end
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      checks++; if (bus_if.o_busy !== 1'b0 || bus_if.o_lo !== m_lo) begin errors++; $display("FAIL flush_state: got busy %b lo %h expected busy 0 lo %h", bus_if.o_busy, bus_if.o_lo, m_lo); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int first = -1, second = -1;
      bus_if.i_valid = 1'b1; bus_if.i_op = OP_MULT;
      bus_if.i_operand_a = 32'd6; bus_if.i_operand_b = 32'd7;
      @(posedge clk); #1;
      idle_inputs();
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus_if.o_done) begin first = k; break; end
      end
      model_apply(OP_MULT, 32'd6, 32'd7);
      checks++; if (first != 34 || bus_if.o_lo !== m_lo || bus_if.o_hi !== m_hi) begin errors++; $display("FAIL b2b_first: got cyc %0d %h_%h expected 34 %h_%h", first, bus_if.o_hi, bus_if.o_lo, m_hi, m_lo); end
      bus_if.i_valid = 1'b1; bus_if.i_op = OP_MULT;
      bus_if.i_operand_a = 32'hFFFF_FFFE; bus_if.i_operand_b = 32'd9;
      @(posedge clk); #1;
      idle_inputs();
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus_if.o_done) begin second = k; break; end
      end
      model_apply(OP_MULT, 32'hFFFF_FFFE, 32'd9);
      checks++; if (second != 34) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 34", second); end
      checks++; if (bus_if.o_hi !== m_hi || bus_if.o_lo !== m_lo) begin errors++; $display("FAIL b2b_second_result: got %h_%h expected %h_%h", bus_if.o_hi, bus_if.o_lo, m_hi, m_lo); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int lat, bc;
      logic [2:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 30; i++) begin
         op = 3'($urandom_range(1, 6));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) b = 32'd0;
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         if (op == OP_MTHI || op == OP_MTLO) begin
            bus_if.i_valid = 1'b1; bus_if.i_op = op;
            bus_if.i_operand_a = a; bus_if.i_operand_b = b;
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            @(posedge clk); #1;
         end else begin
            do_op(op, a, b, lat, bc);
            checks++; if (lat != 34) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected 34", i, lat); end
         end
         model_apply(op, a, b);
         checks++; if (bus_if.o_hi !== m_hi) begin errors++; $display("FAIL rand_hi[%0d] op %0d a %h b %h: got %h expected %h", i, op, a, b, bus_if.o_hi, m_hi); end
         checks++; if (bus_if.o_lo !== m_lo) begin errors++; $display("FAIL rand_lo[%0d] op %0d a %h b %h: got %h expected %h", i, op, a, b, bus_if.o_lo, m_lo); end
      end
   endtask

   initial begin
      test_reset();
      test_mult_timing();
      test_directed();
      test_stall_mfhilo();
      test_mt();
      test_reset_mid();
      test_flush();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
